// File: rtl/m_mem_ctrl.sv
// rtl/m_mem_ctrl.sv - M-stage data-memory access controller with req/ack handshake and timeout
module m_mem_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  ext_a,
    output logic [2:0]  ext_op,
    output logic [31:0] ext_din,
    input  logic [31:0] ext_dout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             flush_kill;
    logic             to_err;
    logic             lat_we;
    logic             op_ok, align_ok, legal;
    logic             start, reject, timeout_hit;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;

    always_comb begin
        op_ok    = 1'b1;
        align_ok = 1'b1;
        case (req_op)
            3'b000:  align_ok = (req_addr[1:0] == 2'b00);
            3'b001:  op_ok = 1'b1;
            3'b010:  op_ok = !req_we;
            3'b011:  align_ok = !req_addr[0];
            3'b100: begin
                op_ok    = !req_we;
                align_ok = !req_addr[0];
            end
            default: op_ok = 1'b0;
        endcase
    end

    assign legal  = op_ok && align_ok;
    // Gated by rst_n so a reset held against a pending request releases the pipeline at once.
    assign start  = rst_n && (state == IDLE) && req_valid && !flush && legal;
    assign reject = (state == IDLE) && req_valid && !flush && !legal;
    assign timeout_hit = (TIMEOUT != 0) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = req_we ? req_wdata : 32'h0;
        if (req_we) begin
            case (req_op)
                3'b001: begin
                    be_next    = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
                3'b011: begin
                    be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = req_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            flush_kill <= 1'b0;
            to_err     <= 1'b0;
            lat_we     <= 1'b0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
            ext_a      <= 2'b00;
            ext_op     <= 3'b000;
            ext_din    <= 32'h0;
        end else begin
            exc_adel <= reject && !req_we;
            exc_ades <= reject && req_we;
            if (start) begin
                cnt        <= '0;
                flush_kill <= 1'b0;
                to_err     <= 1'b0;
                lat_we     <= req_we;
                mem_we     <= req_we;
                mem_addr   <= {req_addr[31:2], 2'b00};
                mem_be     <= be_next;
                mem_wdata  <= wdata_next;
                ext_a      <= req_addr[1:0];
                ext_op     <= req_we ? 3'b000 : req_op;
            end else if (state == BUSY) begin
                if (!mem_ack)   cnt <= cnt + 1'b1;
                if (mem_ack)    ext_din <= mem_rdata;
                if (timeout_hit) to_err <= 1'b1;
                // The access still completes on the bus; only the result is discarded.
                if (flush)      flush_kill <= 1'b1;
            end
        end
    end

    assign stall   = start || (state == BUSY);
    assign mem_req = (state == BUSY);
    assign done    = (state == DONE);
    assign bus_err = (state == DONE) && to_err && !flush_kill;
    assign ld_data = ((state == DONE) && !lat_we && !to_err && !flush_kill) ? ext_dout : 32'h0;

endmodule
